// File: rtl/nn_seq_if.sv
// Command/status and memory-control bundle between the nn sequencer and its host/datapath.
interface nn_seq_if #(
    parameter int A  = 10,
    parameter int ND = 3,
    parameter int CT = 9
);
    logic          start;
    logic          mode;
    logic [15:0]   batch;
    logic [15:0]   max_iter;
    logic          abort;
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic          err;
    logic [A-1:0]  x_addr;
    logic [A-1:0]  y_addr;
    logic [A-1:0]  t_addr;
    logic [A-1:0]  nd_addr;
    logic          e_x;
    logic          e_nd;
    logic          in_we;
    logic [ND-1:0] c_we;
    logic          y_we;
    logic          nd_we;
    logic [CT-1:0] bp_we;
    logic          dtb;

    modport master (
        input  start, mode, batch, max_iter, abort,
        output state, busy, done, err, x_addr, y_addr, t_addr, nd_addr,
               e_x, e_nd, in_we, c_we, y_we, nd_we, bp_we, dtb
    );

    modport slave (
        output start, mode, batch, max_iter, abort,
        input  state, busy, done, err, x_addr, y_addr, t_addr, nd_addr,
               e_x, e_nd, in_we, c_we, y_we, nd_we, bp_we, dtb
    );
endinterface

// File: rtl/nn_seq_ctrl.sv
// Neural-net sequencer: coefficient load, feedforward/backprop batches, coefficient
// write-back and iteration control with a runtime start/done/abort handshake.
module nn_seq_ctrl #(
    parameter int                 LTOT    = 3,
    parameter logic [LTOT*32-1:0] LR      = {32'd1, 32'd2, 32'd2},
    parameter int                 A       = 10,
    parameter int                 ND      = 3,
    parameter int                 WT      = 6,
    parameter int                 T0      = 10,
    parameter int                 MEM_LAT = 1
) (
    input logic      clk,
    input logic      rst,
    nn_seq_if.master bus
);
    localparam int CT  = WT + ND;
    localparam int SX  = int'(LR[31:0]);
    localparam int CW  = 16;
    localparam int LIW = $clog2(LTOT * 32);

    localparam logic [CW-1:0] LOAD_LAST = CW'(CT + MEM_LAT - 1);
    localparam logic [CW-1:0] SMP_LAST  = CW'(SX + MEM_LAT);
    localparam logic [CW-1:0] SAVE_LAST = CW'(CT - 1);
    localparam logic [CW-1:0] IN_FIRST  = CW'(MEM_LAT);
    localparam logic [CW-1:0] IN_LAST   = CW'(SX + MEM_LAT - 1);
    localparam logic [CW-1:0] EX_END    = CW'(SX);
    localparam logic [A-1:0]  T_BASE    = A'(T0);
    localparam logic [ND-1:0] SEL_FIRST = ND'(1) << (ND - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FWD   = 3'd2,
        S_TRAIN = 3'd3,
        S_SAVE  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt, samp, iter;
    logic          mode_q, err_q;
    logic [15:0]   batch_q, max_iter_q;
    logic [A-1:0]  x_q, y_q, t_q;
    logic [ND-1:0] sel;
    logic [31:0]   cap, node, lyr;

    logic          accept, reject, capture, commit, last_smp, cfg_ok;
    logic          e_x, e_nd, in_we, y_we, nd_we, dtb;
    logic [ND-1:0] c_we;
    logic [CT-1:0] bp_we;
    logic [A-1:0]  nd_addr;

    function automatic logic [31:0] layer_size(input logic [31:0] l);
        return LR[LIW'(l * 32) +: 32];
    endfunction

    assign cfg_ok   = (bus.batch != '0) && !(bus.mode && (bus.max_iter == '0));
    assign last_smp = (samp == batch_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        commit  = 1'b0;
        e_x     = 1'b0;
        e_nd    = 1'b0;
        in_we   = 1'b0;
        c_we    = '0;
        y_we    = 1'b0;
        nd_we   = 1'b0;
        bp_we   = '0;
        dtb     = 1'b0;
        nd_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        accept  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        reject  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                // Cycle 0 only primes the memory; data for nd_addr-MEM_LAT arrives afterwards.
                e_nd    = 1'b1;
                nd_addr = A'(cnt);
                capture = (cnt >= IN_FIRST);
                c_we    = capture ? sel : '0;
                if (cnt == LOAD_LAST) state_d = mode_q ? S_TRAIN : S_FWD;
            end
            S_FWD, S_TRAIN: begin
                e_x   = (cnt < EX_END);
                in_we = (cnt >= IN_FIRST) && (cnt <= IN_LAST);
                if (cnt == SMP_LAST) begin
                    commit = 1'b1;
                    if (state_q == S_TRAIN) bp_we = '1;
                    else                    y_we  = 1'b1;
                    if (last_smp) state_d = (state_q == S_TRAIN) ? S_SAVE : S_DONE;
                end
            end
            S_SAVE: begin
                dtb     = 1'b1;
                nd_we   = 1'b1;
                nd_addr = A'(cnt);
                bp_we   = CT'(1) << cnt;
                if (cnt == SAVE_LAST) state_d = (iter < max_iter_q) ? S_LOAD : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            accept  = 1'b0;
            reject  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            mode_q     <= 1'b0;
            batch_q    <= '0;
            max_iter_q <= '0;
        end else if (accept) begin
            err_q      <= 1'b0;
            mode_q     <= bus.mode;
            batch_q    <= bus.batch;
            max_iter_q <= bus.max_iter;
        end else if (reject) begin
            err_q      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            cnt  <= '0;
            samp <= '0;
            iter <= '0;
            x_q  <= '0;
            y_q  <= '0;
            t_q  <= T_BASE;
            sel  <= SEL_FIRST;
            cap  <= '0;
            node <= '0;
            lyr  <= 32'd1;
        end else begin
            if (state_d != state_q || commit)              cnt <= '0;
            else if (state_q != S_IDLE && state_q != S_DONE) cnt <= cnt + CW'(1);
            else                                            cnt <= '0;

            if (accept) begin
                samp <= '0;
                iter <= '0;
            end

            if (e_x) x_q <= x_q + A'(1);

            // The last commit of a training batch rewinds the sample memories for the next pass.
            if (commit) begin
                samp <= last_smp ? '0 : samp + CW'(1);
                if (last_smp && state_q == S_TRAIN) begin
                    iter <= iter + CW'(1);
                    x_q  <= '0;
                    y_q  <= '0;
                    t_q  <= T_BASE;
                end else begin
                    y_q  <= y_q + A'(1);
                    t_q  <= t_q + A'(1);
                end
            end

            if (state_d == S_LOAD && state_q != S_LOAD) begin
                sel  <= SEL_FIRST;
                cap  <= '0;
                node <= '0;
                lyr  <= 32'd1;
            end else if (capture) begin
                // A node in layer l takes LR[l-1] weights plus one bias.
                if (cap == layer_size(lyr - 32'd1)) begin
                    cap <= '0;
                    sel <= sel >> 1;
                    if (node == layer_size(lyr) - 32'd1) begin
                        node <= '0;
                        if (lyr < 32'(LTOT - 1)) lyr <= lyr + 32'd1;
                    end else begin
                        node <= node + 32'd1;
                    end
                end else begin
                    cap <= cap + 32'd1;
                end
            end
        end
    end

    assign bus.state   = state_q;
    assign bus.busy    = (state_q == S_LOAD) || (state_q == S_FWD) ||
                         (state_q == S_TRAIN) || (state_q == S_SAVE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = err_q;
    assign bus.x_addr  = x_q;
    assign bus.y_addr  = y_q;
    assign bus.t_addr  = t_q;
    assign bus.nd_addr = nd_addr;
    assign bus.e_x     = e_x;
    assign bus.e_nd    = e_nd;
    assign bus.in_we   = in_we;
    assign bus.c_we    = c_we;
    assign bus.y_we    = y_we;
    assign bus.nd_we   = nd_we;
    assign bus.bp_we   = bp_we;
    assign bus.dtb     = dtb;
endmodule
